// File: rtl/fpu_uart_pkg.sv
// rtl/fpu_uart_pkg.sv - shared types and constants for the FPU UART front end
package fpu_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 348;
    localparam int CPB_MIN              = 2;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 receiver: synchroniser, bit FSM and shift register
module uart_rx_byte
    import fpu_uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int CPB_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CPB_W-1:0]     i_clks_per_bit,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_byte,
    output logic                 o_byte_valid,
    output logic                 o_frame_err,
    output logic                 o_busy,
    output logic                 o_stop_ok,
    output logic                 o_stop_err,
    output logic [DATA_BITS-1:0] o_shift
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    rx_state_t              r_state;
    logic [CPB_W-1:0]       r_cnt;
    logic [CPB_W-1:0]       r_cpb;
    logic [IDX_W-1:0]       r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;

    logic                   w_rx_s;
    logic [CPB_W-1:0]       w_cpb_in;
    logic                   w_half_hit;
    logic                   w_bit_hit;

    assign w_rx_s     = r_sync[SYNC_STAGES-1];
    assign w_cpb_in   = (i_clks_per_bit < CPB_W'(CPB_MIN)) ? CPB_W'(CPB_MIN) : i_clks_per_bit;
    assign w_half_hit = (r_cnt == (r_cpb >> 1) - CPB_W'(1));
    assign w_bit_hit  = (r_cnt == r_cpb - CPB_W'(1));

    // Combinational stop-bit strobes let the word stage update on the same edge as o_byte.
    assign o_stop_ok  = (r_state == STOP) && w_bit_hit && w_rx_s;
    assign o_stop_err = (r_state == STOP) && w_bit_hit && !w_rx_s;
    assign o_shift    = r_shift;
    assign o_busy     = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_cpb        <= CPB_W'(CPB_MIN);
            r_bit_idx    <= '0;
            r_shift      <= '0;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_cpb   <= w_cpb_in;
                        r_cnt   <= '0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_half_hit) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rx_s ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + CPB_W'(1);
                    end
                end
                DATA: begin
                    if (w_bit_hit) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CPB_W'(1);
                    end
                end
                STOP: begin
                    if (w_bit_hit) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            o_byte       <= r_shift;
                            o_byte_valid <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CPB_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_word.sv
// rtl/uart_rx_word.sv - pairs received UART bytes into 16-bit FPU words
module uart_rx_word
    import fpu_uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int CPB_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CPB_W-1:0]     CLKS_PER_BIT,
    input  logic                 r_Rx_Serial,
    input  logic                 i_word_clear,
    output logic [DATA_BITS-1:0] o_byte,
    output logic                 o_byte_valid,
    output logic [15:0]          o_word,
    output logic                 o_word_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    logic                 w_stop_ok;
    logic                 w_stop_err;
    logic [DATA_BITS-1:0] w_shift;
    logic                 r_half;
    logic [DATA_BITS-1:0] r_low;

    uart_rx_byte #(
        .DATA_BITS   (DATA_BITS),
        .CPB_W       (CPB_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx_byte (
        .clk            (clk),
        .rst            (rst),
        .i_clks_per_bit (CLKS_PER_BIT),
        .i_rx           (r_Rx_Serial),
        .o_byte         (o_byte),
        .o_byte_valid   (o_byte_valid),
        .o_frame_err    (o_frame_err),
        .o_busy         (o_busy),
        .o_stop_ok      (w_stop_ok),
        .o_stop_err     (w_stop_err),
        .o_shift        (w_shift)
    );

    // A clear or a framing error both drop any held low byte; clear wins over a completing byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_half       <= 1'b0;
            r_low        <= '0;
            o_word       <= '0;
            o_word_valid <= 1'b0;
        end else begin
            o_word_valid <= 1'b0;
            if (i_word_clear || w_stop_err) begin
                r_half <= 1'b0;
            end else if (w_stop_ok) begin
                if (!r_half) begin
                    r_low  <= w_shift;
                    r_half <= 1'b1;
                end else begin
                    o_word       <= 16'({w_shift, r_low});
                    o_word_valid <= 1'b1;
                    r_half       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- Serial front end for the Bfloat16 FPU.
- Receives 8N1 UART bytes on the rx pad or logic-analyser line and pairs them into 16-bit operand/command words.
- Sits directly upstream of the FPU FSM and presents each completed word with a one-cycle valid strobe.
- Baud rate is set at runtime by CLKS_PER_BIT, which comes from the LA bank or a default of 348.

Parameters:
- DATA_BITS, 8, payload bits per UART frame; LSB is received first.
- CPB_W, 16, width of the CLKS_PER_BIT input and the internal baud counter.
- SYNC_STAGES, 2, number of flops in the rx metastability synchroniser (minimum 2).

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- CLKS_PER_BIT  in  CPB_W  clk cycles per UART bit; latched at start-bit detect.
- r_Rx_Serial  in  1  asynchronous serial line; idles high.
- i_word_clear  in  1  discards any held low byte; the next byte is treated as the low byte.
- o_byte  out  DATA_BITS  last correctly framed byte.
- o_byte_valid  out  1  one-cycle pulse when o_byte updates.
- o_word  out  16  {second byte, first byte}.
- o_word_valid  out  1  one-cycle pulse when o_word updates.
- o_frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: at any clk edge with rst=1, all of the following apply:
  - state goes to IDLE, and the counter and bit index clear;
  - the synchroniser flops are set to 1;
  - the half-word flag clears;
  - o_byte, o_word, all pulses and o_busy go to 0.
  - Reset mid-frame abandons the frame. No pulse is emitted for it.
- Synchroniser: r_Rx_Serial passes through SYNC_STAGES flops; rx_s is the last stage. All decisions use rx_s.
- Latched baud: cpb_q = max(CLKS_PER_BIT, 2), captured on the IDLE->START transition. Changes to CLKS_PER_BIT mid-frame are ignored.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rx_s=0, latch cpb_q, cnt=0, go to START.
  - START: cnt increments each cycle. At cnt == (cpb_q>>1)-1:
    - rx_s=0: cnt=0, bit_idx=0, go to DATA;
    - rx_s=1: glitch; return to IDLE with no pulse.
  - DATA: cnt increments. At cnt == cpb_q-1, shift rx_s into bit position bit_idx and clear cnt. After bit DATA_BITS-1, go to STOP.
  - STOP: at cnt == cpb_q-1:
    - rx_s=1: o_byte <= shift register, o_byte_valid=1;
    - rx_s=0: o_frame_err=1, o_byte is unchanged, the half-word flag clears.
    - Either way, return to IDLE in the same edge. A new start bit may be detected the following cycle.
- Latency: o_byte_valid rises (cpb_q>>1) + (DATA_BITS+1)*cpb_q cycles after the IDLE cycle that sees rx_s=0.
- Word assembly:
  - On a valid byte with the flag clear: hold it as the low byte and set the flag.
  - On a valid byte with the flag set: o_word <= {byte, low}, o_word_valid=1 in the same cycle as o_byte_valid, and the flag clears.
- i_word_clear clears the flag. If it coincides with a second byte's o_byte_valid, the clear wins: no word is emitted and the flag ends clear.
- Pulses are never asserted for more than one cycle. o_byte_valid and o_frame_err are mutually exclusive.
- o_busy=1 exactly when state != IDLE.

Decomposition:
- Shared package fpu_uart_pkg holds:
  - the state enum {IDLE, START, DATA, STOP};
  - DEFAULT_CLKS_PER_BIT = 348;
  - CPB_MIN = 2.
- One natural sub-module: uart_rx_byte (synchroniser + FSM + shift register, emitting byte/valid/frame_err).
- uart_rx_word adds only the half-word pairing logic.

Test Plan:
- CPB=4, send 0x34 then 0x12 at ideal timing → o_byte_valid pulses with 0x34 then 0x12; o_word=0x1234 with o_word_valid coincident with the second byte pulse. Check the latency formula (2+9*4=38 cycles from start detect).
- CPB=4, rx low for 1 cycle then high → FSM returns to IDLE; no byte, word or error pulse; o_busy high for 3 cycles at most.
- CPB=8, send 0xA5 with stop bit forced 0 → o_frame_err pulse and no o_byte_valid. Then send 0x01, 0x02 → o_word=0x0201, confirming the pending half was discarded.
- CPB=6, send 0x55; change CLKS_PER_BIT to 3 mid-frame → byte 0x55 received correctly at 6-cycle bit timing.
- Send 0xEE; pulse i_word_clear; send 0x11, 0x22 → o_word=0x2211, no word containing 0xEE.
- Assert rst during DATA of frame 0x7F, release, send 0x0F, 0xF0 → no pulse from the aborted frame; o_word=0xF00F. CLKS_PER_BIT=0 or 1 behaves as 2.
